// File: rtl/pc_fetch.sv
// Instruction-fetch stage: fetch PC, instruction-memory request/ack handshake,
// redirect handling for in-flight requests, and the IF/ID pipeline register.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        pc_src_id,
    input  logic [31:0] pc_branch_id,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_wait,
    output logic [31:0] instr_id,
    output logic [31:0] pc_plus4_id,
    output logic        valid_id
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request outstanding on the current pc
        S_HELD = 2'd1,  // instruction captured in r_buf, downstream stalled
        S_DROP = 2'd2   // wrong-path request outstanding, redirect pending in r_target
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_buf, w_buf_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_pc4, w_pc4_nxt;
    logic        r_valid, w_valid_nxt;

    logic        w_hold;
    logic [31:0] w_pc_inc;
    logic [31:0] w_drop_dest;

    assign w_hold      = stall_if | stall_id;
    assign w_pc_inc    = r_pc + 32'd4;
    // A redirect arriving while a wrong-path request is in flight replaces the pending target.
    assign w_drop_dest = pc_src_id ? pc_branch_id : r_target;

    assign imem_req  = rst_n & (r_state != S_HELD);
    assign imem_addr = r_pc;
    assign imem_wait = imem_req & ~imem_ack;

    assign instr_id    = r_instr;
    assign pc_plus4_id = r_pc4;
    assign valid_id    = r_valid;

    always_comb begin
        // NOTE: every next-state signal is defaulted to its current value first so that
        // branches which leave it untouched cannot infer a latch.
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_buf_nxt    = r_buf;
        w_target_nxt = r_target;
        w_instr_nxt  = r_instr;
        w_pc4_nxt    = r_pc4;
        w_valid_nxt  = r_valid;

        unique case (r_state)
            S_REQ: begin
                if (w_hold) begin
                    if (imem_ack) begin
                        w_buf_nxt   = imem_rdata;
                        w_state_nxt = S_HELD;
                    end
                end else if (pc_src_id) begin
                    w_instr_nxt = 32'd0;
                    w_valid_nxt = 1'b0;
                    if (imem_ack) begin
                        w_pc_nxt = pc_branch_id;
                    end else begin
                        w_target_nxt = pc_branch_id;
                        w_state_nxt  = S_DROP;
                    end
                end else if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_pc4_nxt   = w_pc_inc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                end else begin
                    w_instr_nxt = 32'd0;
                    w_valid_nxt = 1'b0;
                end
            end

            S_HELD: begin
                if (!w_hold) begin
                    w_state_nxt = S_REQ;
                    if (pc_src_id) begin
                        w_pc_nxt    = pc_branch_id;
                        w_instr_nxt = 32'd0;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_instr_nxt = r_buf;
                        w_pc4_nxt   = w_pc_inc;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                    end
                end
            end

            S_DROP: begin
                // Under hold everything freezes; the wrong-path request is simply reissued.
                if (!w_hold) begin
                    w_instr_nxt  = 32'd0;
                    w_valid_nxt  = 1'b0;
                    w_target_nxt = w_drop_dest;
                    if (imem_ack) begin
                        w_pc_nxt    = w_drop_dest;
                        w_state_nxt = S_REQ;
                    end
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            // NOTE: the instruction buffer is a single register, not an array, so it is
            // cleared in reset like the rest of the state.
            r_buf    <= 32'd0;
            r_target <= 32'd0;
            r_instr  <= 32'd0;
            r_pc4    <= 32'd0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_buf    <= w_buf_nxt;
            r_target <= w_target_nxt;
            r_instr  <= w_instr_nxt;
            r_pc4    <= w_pc4_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_pc_fetch;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n, stall_if, stall_id, pc_src_id, imem_ack;
    logic [31:0] pc_branch_id, imem_rdata;
    logic        imem_req, imem_wait, valid_id;
    logic [31:0] imem_addr, instr_id, pc_plus4_id;

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .pc_src_id   (pc_src_id),
        .pc_branch_id(pc_branch_id),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .imem_wait   (imem_wait),
        .instr_id    (instr_id),
        .pc_plus4_id (pc_plus4_id),
        .valid_id    (valid_id)
    );

    int checks = 0;
    int errors = 0;

    // Model: the fetch pc, whether a fetched word is parked waiting for the stall to clear,
    // whether the outstanding request is on the wrong path (and where to go afterwards),
    // and the three IF/ID outputs.
    logic [31:0] m_pc, m_buf, m_target, m_instr, m_pc4;
    bit          m_parked, m_wrong_path, m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_buf = 32'h0; m_target = 32'h0;
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_parked = 1'b0; m_wrong_path = 1'b0;
    endtask

    task automatic compare_model();
        bit exp_req;
        exp_req = rst_n && !m_parked;
        check("m_imem_req",  {31'd0, imem_req},  {31'd0, exp_req});
        check("m_imem_wait", {31'd0, imem_wait}, {31'd0, exp_req && !imem_ack});
        check("m_imem_addr", imem_addr, m_pc);
        check("m_instr_id",  instr_id, m_instr);
        check("m_pc_plus4",  pc_plus4_id, m_pc4);
        check("m_valid_id",  {31'd0, valid_id}, {31'd0, m_valid});
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        logic [31:0] dest;
        if (!rst_n) begin
            model_reset();
        end else if (stall_if || stall_id) begin
            if (!m_parked && !m_wrong_path && imem_ack) begin
                m_parked = 1'b1;
                m_buf    = imem_rdata;
            end
        end else if (m_parked) begin
            m_parked = 1'b0;
            if (pc_src_id) begin
                m_pc = pc_branch_id; m_instr = 0; m_valid = 0;
            end else begin
                m_instr = m_buf; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            end
        end else if (m_wrong_path) begin
            m_instr = 0; m_valid = 0;
            dest = pc_src_id ? pc_branch_id : m_target;
            m_target = dest;
            if (imem_ack) begin
                m_pc = dest; m_wrong_path = 1'b0;
            end
        end else if (pc_src_id) begin
            m_instr = 0; m_valid = 0;
            if (imem_ack) m_pc = pc_branch_id;
            else begin
                m_target = pc_branch_id; m_wrong_path = 1'b1;
            end
        end else if (imem_ack) begin
            m_instr = imem_rdata; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
        end else begin
            m_instr = 0; m_valid = 0;
        end
    endtask

    // Called at a falling edge: apply inputs, let memory data follow the address.
    task automatic drive(input bit rn, input bit sif, input bit sid, input bit src,
                         input logic [31:0] br, input bit ack, input bit rand_data);
        rst_n = rn; stall_if = sif; stall_id = sid; pc_src_id = src;
        pc_branch_id = br; imem_ack = ack;
        #1;
        imem_rdata = rand_data ? $urandom : (imem_addr ^ K);
        #1;
    endtask

    task automatic tick();
        compare_model();
        model_step();
        @(negedge clk);
    endtask

    task automatic go(input bit rn, input bit sif, input bit sid, input bit src,
                      input logic [31:0] br, input bit ack);
        drive(rn, sif, sid, src, br, ack, 1'b0);
        tick();
    endtask

    task automatic lit_ifid(input string name, input logic [31:0] ins, input logic [31:0] p4,
                            input bit v);
        check({name, "_instr"}, instr_id, ins);
        check({name, "_pc4"}, pc_plus4_id, p4);
        check({name, "_valid"}, {31'd0, valid_id}, {31'd0, v});
    endtask

    initial begin
        rst_n = 0; stall_if = 0; stall_id = 0; pc_src_id = 0;
        pc_branch_id = 0; imem_ack = 1; imem_rdata = 0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset: request suppressed, IF/ID cleared, ack ignored.
        drive(0, 0, 0, 0, 0, 1, 0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        tick();
        lit_ifid("rst", 32'h0, 32'h0, 0);

        // Zero-wait streaming from RESET_PC.
        drive(1, 0, 0, 0, 0, 1, 0);
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        tick();
        lit_ifid("stream0", 32'hA5A5_A5A5, 32'd4, 1);
        go(1, 0, 0, 0, 0, 1);
        lit_ifid("stream1", 32'hA5A5_A5A1, 32'd8, 1);

        // Three wait cycles at pc 8.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            check("wait_flag", {31'd0, imem_wait}, 32'd1);
            check("wait_addr", imem_addr, 32'd8);
            tick();
            lit_ifid("wait_bubble", 32'h0, 32'd8, 0);
        end
        go(1, 0, 0, 0, 0, 1);
        lit_ifid("after_wait", 32'hA5A5_A5AD, 32'd12, 1);
        go(1, 0, 0, 0, 0, 1);
        lit_ifid("pc12", 32'hA5A5_A5A9, 32'd16, 1);

        // Ack under hold at pc 16, hold for two cycles (redirect ignored while held).
        go(1, 1, 0, 0, 0, 1);
        check("held_req", {31'd0, imem_req}, 32'd0);
        lit_ifid("held1", 32'hA5A5_A5A9, 32'd16, 1);
        go(1, 0, 1, 1, 32'h500, 1);
        lit_ifid("held2", 32'hA5A5_A5A9, 32'd16, 1);
        go(1, 0, 0, 0, 0, 0);
        lit_ifid("release", 32'hA5A5_A5B5, 32'd20, 1);
        check("release_addr", imem_addr, 32'd20);
        go(1, 0, 0, 0, 0, 1);
        lit_ifid("pc20", 32'hA5A5_A5B1, 32'd24, 1);

        // Redirect to 0x100 with ack pending at pc 24.
        go(1, 0, 0, 1, 32'h100, 0);
        lit_ifid("drop0", 32'h0, 32'd24, 0);
        check("drop_addr0", imem_addr, 32'd24);
        go(1, 0, 0, 0, 0, 0);
        check("drop_addr1", imem_addr, 32'd24);
        go(1, 0, 0, 0, 0, 1);
        lit_ifid("drop_ack", 32'h0, 32'd24, 0);
        check("drop_target", imem_addr, 32'h100);
        go(1, 0, 0, 0, 0, 1);
        lit_ifid("target", 32'hA5A5_A4A5, 32'h104, 1);

        // Redirect under hold ignored; redirect with ack taken.
        go(1, 1, 0, 1, 32'h200, 0);
        lit_ifid("redir_hold", 32'hA5A5_A4A5, 32'h104, 1);
        check("redir_hold_addr", imem_addr, 32'h104);
        go(1, 0, 0, 1, 32'h300, 1);
        lit_ifid("redir_ack", 32'h0, 32'h104, 0);
        check("redir_ack_addr", imem_addr, 32'h300);

        // Wrap of pc+4 and unaligned target pass-through.
        go(1, 0, 0, 1, 32'hFFFF_FFFC, 1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        go(1, 0, 0, 0, 0, 1);
        lit_ifid("wrap", 32'h5A5A_5A59, 32'h0, 1);
        check("wrap_next", imem_addr, 32'h0);
        go(1, 0, 0, 1, 32'h1003, 1);
        check("unaligned", imem_addr, 32'h1003);

        // Reset in the middle of a wrong-path request.
        go(1, 0, 0, 1, 32'h40, 0);
        go(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("drop_rst_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("drop_rst_valid", {31'd0, valid_id}, 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);
        tick();
        go(1, 0, 0, 0, 0, 1);
        lit_ifid("post_rst", 32'hA5A5_A5A5, 32'd4, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] br;
            br = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
            drive($urandom_range(0, 99) != 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0,
                  br,
                  $urandom_range(0, 2) != 0,
                  1'b1);
            tick();
        end
        compare_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports stall_if  in  1 and stall_id  in  1, hazard-unit stalls; hold = stall_if | stall_id.
REQ-005 SHALL have port pc_src_id  in  1  branch/jump taken, resolved in ID.
REQ-006 SHALL have port pc_branch_id  in  32  redirect target.
REQ-007 SHALL have ports imem_req  out  1, imem_addr  out  32, imem_ack  in  1, imem_rdata  in  32  instruction-memory handshake.
REQ-008 SHALL have port imem_wait  out  1  fetch-not-ready indication to hazard unit.
REQ-009 SHALL have ports instr_id  out  32, pc_plus4_id  out  32, valid_id  out  1  IF/ID register contents.

Function
REQ-010 SHALL keep fetch PC register pc; imem_addr = pc.
REQ-011 SHALL implement FSM states S_REQ (request outstanding), S_HELD (instruction buffered, downstream held), S_DROP (wrong-path request outstanding).
REQ-012 SHALL drive imem_req = 1 in S_REQ and S_DROP, 0 in S_HELD.
REQ-013 SHALL keep imem_addr stable while imem_req = 1 and imem_ack = 0.
REQ-014 SHALL drive imem_wait = imem_req & ~imem_ack (combinational).
REQ-015 Bubble SHALL mean instr_id = 0, valid_id = 0, pc_plus4_id unchanged.
REQ-016 S_REQ, ack, ~hold, ~pc_src_id: instr_id <= imem_rdata, pc_plus4_id <= pc+4, valid_id <= 1, pc <= pc+4, stay S_REQ.
REQ-017 S_REQ, ack, hold: buffer <= imem_rdata, pc and IF/ID unchanged, go S_HELD.
REQ-018 S_REQ, ~ack, ~hold, ~pc_src_id: IF/ID <= bubble, stay S_REQ.
REQ-019 S_HELD, ~hold, ~pc_src_id: instr_id <= buffer, pc_plus4_id <= pc+4, valid_id <= 1, pc <= pc+4, go S_REQ.
REQ-020 Redirect (pc_src_id & ~hold) in S_REQ with ack: discard imem_rdata, pc <= pc_branch_id, IF/ID <= bubble, stay S_REQ.
REQ-021 Redirect in S_REQ without ack: target <= pc_branch_id, IF/ID <= bubble, go S_DROP; pc unchanged (REQ-013).
REQ-022 Redirect in S_HELD: discard buffer, pc <= pc_branch_id, IF/ID <= bubble, go S_REQ.
REQ-023 S_DROP: IF/ID <= bubble when ~hold; on ack discard imem_rdata, pc <= target, go S_REQ.
REQ-024 Redirect in S_DROP: overwrite target (last wins).
REQ-025 hold = 1: IF/ID, pc unchanged; pc_src_id ignored.
REQ-026 pc+4 SHALL wrap modulo 2^32; bits [1:0] of pc_branch_id passed unchanged.
REQ-027 Zero-wait memory (ack with req), no hold: one instruction per cycle; instruction at pc appears on instr_id one cycle after ack.

Reset
REQ-028 While rst_n = 0 at clock edge: pc <= RESET_PC, state <= S_REQ, instr_id <= 0, pc_plus4_id <= 0, valid_id <= 0, buffer <= 0, target <= 0.
REQ-029 imem_req SHALL be 0 while rst_n = 0; reset mid-request abandons it, ack during reset ignored.
REQ-030 First request SHALL issue in the first cycle with rst_n = 1, addr = RESET_PC.

Verification
REQ-031 Reset release, ack tied 1, rdata = addr ^ 32'hA5A5_A5A5 -> instr_id = 32'hA5A5_A5A5 then 32'hA5A5_A5A1, pc_plus4_id = 4, 8, valid_id = 1 every cycle.
REQ-032 Ack delayed 3 cycles at pc = 8 -> imem_wait = 1 three cycles, addr held 8, three bubbles, then instr at 8 with pc_plus4_id = 12.
REQ-033 Ack at pc = 16 with hold = 1 for 2 cycles -> S_HELD, imem_req = 0, IF/ID frozen; hold release -> instr of 16, pc_plus4_id = 20, next req addr 20.
REQ-034 pc_src_id = 1, target 32'h0000_0100, ack pending at pc = 24 -> S_DROP, addr held 24 until ack, data discarded, next req addr 0x100, only bubbles in between.
REQ-035 pc_src_id = 1 while hold = 1 -> ignored; redirect with ack same cycle -> next addr = target, IF/ID bubble.
REQ-036 rst_n = 0 mid S_DROP -> next cycle pc = RESET_PC, valid_id = 0, imem_req = 0, state S_REQ.
